mems_scan_sequencer: RTL and testbench
======================================

Name: mems_scan_sequencer

Overview:
- Parametrised MEMS mirror DAC command sequencer.
- Sends N_INIT one-shot setup commands, then loops over a scan table of SCAN_LEN points through the MEMS SPI master.
- Raises sticky new_line / new_frame markers for the capture FIFO path, computed by counters instead of hard-coded addresses.
- Adds pause, go-home, marker-overrun reporting and an external 1-cycle synchronous command ROM.

Parameters:
ADDR_W, 16, command ROM address width
DATA_W, 24, SPI command word width
N_INIT, 2, setup commands at ROM addresses 0..N_INIT-1
SCAN_BASE, 8, ROM address of scan point 0; loop restart address
SCAN_LEN, 9600, scan points per loop (SCAN_BASE+SCAN_LEN <= 2**ADDR_W)
POINTS_PER_LINE, 480, points between line markers
LINES_PER_FRAME, 10, line markers per frame marker
MARK_OFFSET, 352, scan index of first marker
HOME_ADDR, 4, ROM address of park/home command
FRAME_ALSO_LINE, 0, 1: frame marker also sets new_line; 0: frame marker replaces line marker

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_init  in  1  pulse: begin init sequence from IDLE (ignored elsewhere)
pause  in  1  level: hold before launching the next scan command
go_home  in  1  level: park mirror at HOME_ADDR
spi_busy  in  1  SPI master busy
rom_data  in  DATA_W  ROM output, valid 1 cycle after rom_addr
line_done  in  1  FIFO consumed new_line
frame_done  in  1  FIFO consumed new_frame
rom_addr  out  ADDR_W  registered ROM address
spi_start  out  1  1-cycle launch pulse
data_mosi  out  DATA_W  = rom_data (combinational pass-through)
new_line  out  1  sticky line marker
new_frame  out  1  sticky frame marker
marker_overrun  out  1  1-cycle pulse: marker set while same flag already pending
scan_wrap  out  1  1-cycle pulse on loop restart
busy  out  1  high in any state except IDLE/HOLD

Behaviour:
- Reset values (async, rst_n=0): state IDLE, rom_addr=0, all counters 0, every output 0.
- States: IDLE, LOAD, FIRE, WAIT, HOLD. Mode register: INIT / SCAN / HOME.
- IDLE: start_init=1 -> mode INIT, rom_addr=0, LOAD.
- LOAD: one cycle for ROM read; -> FIRE.
- FIRE: spi_start=1 for exactly this cycle; -> WAIT.
- WAIT: ignores spi_busy on the first WAIT cycle, since the SPI master raises busy one cycle late. Advances when spi_busy=0 afterwards; this is the completion point.
- INIT completion:
  - If rom_addr < N_INIT-1: rom_addr+1, LOAD.
  - Else: mode SCAN, rom_addr=SCAN_BASE, scan index p=0, LOAD.
- SCAN completion, point p:
  - Evaluate markers for p.
  - If p=SCAN_LEN-1: rom_addr=SCAN_BASE, p=0, scan_wrap pulse, marker counters reset.
  - Else: rom_addr+1, p+1.
  - Next state is LOAD only if pause=0. If pause=1, stay in WAIT with addresses already advanced; resume next cycle pause=0. Pause never truncates a transfer in flight.
- Marker rule:
  - Line marker at p >= MARK_OFFSET with (p-MARK_OFFSET) mod POINTS_PER_LINE = 0. Implemented with a down-counter, no divider.
  - Line markers are numbered k=0,1,...; frame marker when k mod LINES_PER_FRAME = 0.
  - Frame marker sets new_frame. It also sets new_line only if FRAME_ALSO_LINE=1.
- Flags:
  - Set on the completion cycle (visible next cycle); cleared by *_done.
  - Set and done in the same cycle: set wins.
  - Set while already 1: flag stays 1, marker_overrun pulses.
- go_home:
  - Sampled only at SCAN/INIT completion, or while IDLE.
  - Issues one command from HOME_ADDR (mode HOME), then HOLD.
  - HOLD stays while go_home=1. On go_home=0 -> mode SCAN at rom_addr=SCAN_BASE, p=0, markers reset.
  - If go_home asserts mid-transfer, that transfer completes first.
- Simultaneous pause and go_home at completion: go_home wins.
- start_init outside IDLE is ignored.
- Reset mid-transfer: immediate return to IDLE with outputs 0; no completion pulse.

Decomposition:
- Shared package mems_pkg holds:
  - state encoding: IDLE, LOAD, FIRE, WAIT, HOLD
  - mode encoding: INIT, SCAN, HOME
  - default SCAN_BASE, HOME_ADDR, DATA_W constants
- One natural sub-module: mems_marker_gen. It holds the point down-counter and line/frame counters, and outputs line_hit and frame_hit on an advance strobe.

Test Plan:
- Small params for all scenarios: N_INIT=2, SCAN_BASE=8, SCAN_LEN=12, POINTS_PER_LINE=4, LINES_PER_FRAME=2, MARK_OFFSET=1, HOME_ADDR=4, FRAME_ALSO_LINE=0. SPI model holds busy 3 cycles after the start pulse.
- Init order: start_init pulse -> spi_start at rom_addr 0, 1, then 8, 9, 10...; exactly one spi_start per transfer, none while busy.
- Markers: run one full loop -> new_frame set after p=1 and p=9, new_line after p=5 only. scan_wrap pulses after p=11, then rom_addr returns to 8.
- Flag handshake and overrun:
  - Hold line_done=0 across two line markers -> marker_overrun pulses once.
  - line_done in the same cycle as a set -> new_line stays 1.
- Pause: pause=1 during the p=3 transfer -> transfer completes, rom_addr=12, no spi_start until pause drops, then next start at addr 12.
- Home: go_home=1 at p=6 -> p=6 finishes, one command at addr 4, HOLD. Release -> restart at addr 8 with counters cleared.
- Reset: rst_n low during WAIT -> all outputs 0 immediately; re-init works.

Source files
------------

// File: rtl/mems_pkg.sv
// Shared types and default constants for the MEMS scan sequencer.
package mems_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FIRE = 3'd2,
    ST_WAIT = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_INIT = 2'd0,
    MODE_SCAN = 2'd1,
    MODE_HOME = 2'd2
  } mode_t;

  localparam int unsigned DEF_SCAN_BASE = 8;
  localparam int unsigned DEF_HOME_ADDR = 4;
  localparam int unsigned DEF_DATA_W    = 24;

endpackage

// File: rtl/mems_marker_gen.sv
// Line/frame marker generator: a distance down-counter to the next line marker
// and a line counter modulo LINES_PER_FRAME; hits are valid on the advance strobe.
module mems_marker_gen #(
  parameter int unsigned POINTS_PER_LINE = 480,
  parameter int unsigned LINES_PER_FRAME = 10,
  parameter int unsigned MARK_OFFSET     = 352
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  output logic line_hit_c,
  output logic frame_hit_c
);

  localparam int unsigned CNT_MAX = (MARK_OFFSET > POINTS_PER_LINE - 1) ? MARK_OFFSET
                                                                        : POINTS_PER_LINE - 1;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam int unsigned LINE_W  = (LINES_PER_FRAME < 2) ? 1 : $clog2(LINES_PER_FRAME);

  logic [CNT_W-1:0]  dist_q;
  logic [LINE_W-1:0] line_q;

  // Hits describe the point being completed; clear restarts at scan index 0.
  assign line_hit_c  = advance && (dist_q == '0);
  assign frame_hit_c = line_hit_c && (line_q == '0);

  // Counter update: clear has priority so a wrap can evaluate and restart together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_q <= '0;
      line_q <= '0;
    end else if (clear) begin
      dist_q <= CNT_W'(MARK_OFFSET);
      line_q <= '0;
    end else if (advance) begin
      if (dist_q == '0) begin
        dist_q <= CNT_W'(POINTS_PER_LINE - 1);
        line_q <= (line_q == LINE_W'(LINES_PER_FRAME - 1)) ? '0 : line_q + LINE_W'(1);
      end else begin
        dist_q <= dist_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mems_scan_sequencer.sv
// MEMS mirror DAC command sequencer: init commands, looping scan table,
// sticky line/frame markers, pause and park-at-home.
module mems_scan_sequencer
  import mems_pkg::*;
#(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = DEF_DATA_W,
  parameter int unsigned N_INIT          = 2,
  parameter int unsigned SCAN_BASE       = DEF_SCAN_BASE,
  parameter int unsigned SCAN_LEN        = 9600,
  parameter int unsigned POINTS_PER_LINE = 480,
  parameter int unsigned LINES_PER_FRAME = 10,
  parameter int unsigned MARK_OFFSET     = 352,
  parameter int unsigned HOME_ADDR       = DEF_HOME_ADDR,
  parameter bit          FRAME_ALSO_LINE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_init,
  input  logic              pause,
  input  logic              go_home,
  input  logic              spi_busy,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              line_done,
  input  logic              frame_done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              spi_start,
  output logic [DATA_W-1:0] data_mosi,
  output logic              new_line,
  output logic              new_frame,
  output logic              marker_overrun,
  output logic              scan_wrap,
  output logic              busy
);

  localparam int unsigned PW = (SCAN_LEN < 2) ? 1 : $clog2(SCAN_LEN);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PW-1:0]     p_q, p_d;
  logic              first_q, first_d;
  logic              paused_q, paused_d;
  logic              line_q, line_d, frame_q, frame_d;
  logic              ovr_q, ovr_d, wrap_q, wrap_d, start_q, start_d, busy_q, busy_d;
  logic              advance, clear, line_hit, frame_hit, set_line;

  assign data_mosi      = rom_data;
  assign rom_addr       = addr_q;
  assign spi_start      = start_q;
  assign new_line       = line_q;
  assign new_frame      = frame_q;
  assign marker_overrun = ovr_q;
  assign scan_wrap      = wrap_q;
  assign busy           = busy_q;

  mems_marker_gen #(
    .POINTS_PER_LINE (POINTS_PER_LINE),
    .LINES_PER_FRAME (LINES_PER_FRAME),
    .MARK_OFFSET     (MARK_OFFSET)
  ) u_marker (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .advance     (advance),
    .line_hit_c  (line_hit),
    .frame_hit_c (frame_hit)
  );

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_INIT;
      addr_q   <= '0;
      p_q      <= '0;
      first_q  <= 1'b0;
      paused_q <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      ovr_q    <= 1'b0;
      wrap_q   <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      p_q      <= p_d;
      first_q  <= first_d;
      paused_q <= paused_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      ovr_q    <= ovr_d;
      wrap_q   <= wrap_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state, address sequencing and marker flag logic.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    p_d      = p_q;
    first_d  = first_q;
    paused_d = paused_q;
    advance  = 1'b0;
    clear    = 1'b0;
    wrap_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (go_home) begin
          mode_d  = MODE_HOME;
          addr_d  = ADDR_W'(HOME_ADDR);
          state_d = ST_LOAD;
        end else if (start_init) begin
          mode_d  = MODE_INIT;
          addr_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_FIRE;
      ST_FIRE: begin
        state_d  = ST_WAIT;
        first_d  = 1'b1;
        paused_d = 1'b0;
      end
      ST_WAIT: begin
        if (paused_q) begin
          // Transfer already completed; only the pause release matters here.
          if (!pause) begin
            paused_d = 1'b0;
            state_d  = ST_LOAD;
          end
        end else if (first_q) begin
          // SPI master raises busy one cycle after the launch pulse.
          first_d = 1'b0;
        end else if (!spi_busy) begin
          unique case (mode_q)
            MODE_INIT: begin
              state_d = ST_LOAD;
              if (go_home) begin
                mode_d = MODE_HOME;
                addr_d = ADDR_W'(HOME_ADDR);
              end else if (addr_q < ADDR_W'(N_INIT - 1)) begin
                addr_d = addr_q + ADDR_W'(1);
              end else begin
                mode_d = MODE_SCAN;
                addr_d = ADDR_W'(SCAN_BASE);
                p_d    = '0;
                clear  = 1'b1;
              end
            end
            MODE_SCAN: begin
              advance = 1'b1;
              if (p_q == PW'(SCAN_LEN - 1)) begin
                addr_d = ADDR_W'(SCAN_BASE);
                p_d    = '0;
                wrap_d = 1'b1;
                clear  = 1'b1;
              end else begin
                addr_d = addr_q + ADDR_W'(1);
                p_d    = p_q + PW'(1);
              end
              if (go_home) begin
                mode_d  = MODE_HOME;
                addr_d  = ADDR_W'(HOME_ADDR);
                state_d = ST_LOAD;
              end else if (pause) begin
                paused_d = 1'b1;
              end else begin
                state_d = ST_LOAD;
              end
            end
            MODE_HOME: state_d = ST_HOLD;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_HOLD: begin
        if (!go_home) begin
          mode_d  = MODE_SCAN;
          addr_d  = ADDR_W'(SCAN_BASE);
          p_d     = '0;
          clear   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Sticky flags: a set beats a same-cycle done; a set onto a pending flag is an overrun.
    set_line = line_hit & (~frame_hit | FRAME_ALSO_LINE);
    line_d   = set_line | (line_q & ~line_done);
    frame_d  = frame_hit | (frame_q & ~frame_done);
    ovr_d    = (set_line & line_q) | (frame_hit & frame_q);
    start_d  = (state_d == ST_FIRE);
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_HOLD);
  end

endmodule

// File: tb/tb_mems_scan_sequencer.sv
// Self-checking bench: ROM and SPI master models plus a transaction-level
// reference for address order and marker flags.
module tb_mems_scan_sequencer;

  localparam int AW  = 16;
  localparam int DW  = 24;
  localparam int NI  = 2;
  localparam int SB  = 8;
  localparam int SL  = 12;
  localparam int PPL = 4;
  localparam int LPF = 2;
  localparam int MO  = 1;
  localparam int HA  = 4;
  localparam bit FAL = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n, start_init, pause, go_home, spi_busy, line_done, frame_done;
  logic [DW-1:0] rom_data, data_mosi;
  logic [AW-1:0] rom_addr;
  logic          spi_start, new_line, new_frame, marker_overrun, scan_wrap, busy;

  mems_scan_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .N_INIT(NI), .SCAN_BASE(SB), .SCAN_LEN(SL),
    .POINTS_PER_LINE(PPL), .LINES_PER_FRAME(LPF), .MARK_OFFSET(MO),
    .HOME_ADDR(HA), .FRAME_ALSO_LINE(FAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_init(start_init), .pause(pause),
    .go_home(go_home), .spi_busy(spi_busy), .rom_data(rom_data),
    .line_done(line_done), .frame_done(frame_done), .rom_addr(rom_addr),
    .spi_start(spi_start), .data_mosi(data_mosi), .new_line(new_line),
    .new_frame(new_frame), .marker_overrun(marker_overrun),
    .scan_wrap(scan_wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [DW-1:0] rom_mem [0:31];
  logic [AW-1:0] addr_prev;
  int            bcnt, since, cur_addr, exp_addr, n_starts, ovr_seen, line_seen;
  bit            pending, paused, holding, rand_done, start_now;
  logic          e_line, e_frame, e_ovr, e_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Marker rule straight from scan-index arithmetic.
  function automatic void marker(input int p, output bit lh, output bit fh);
    lh = (p >= MO) && (((p - MO) % PPL) == 0);
    fh = lh && ((((p - MO) / PPL) % LPF) == 0);
  endfunction

  task automatic model_reset();
    bcnt = 0; since = 0; pending = 0; paused = 0; holding = 0;
    cur_addr = 0; exp_addr = 0; spi_busy = 1'b0; rom_data = '0; addr_prev = '0;
    e_line = 1'b0; e_frame = 1'b0; e_ovr = 1'b0; e_wrap = 1'b0;
  endtask

  // One clock: predict the edge's effect, advance, update ROM/SPI models, check.
  task automatic tick();
    bit comp, lh, fh, sl, sf, blocked;
    int p;
    if (rand_done) begin
      line_done  = 1'($urandom_range(0, 1));
      frame_done = 1'($urandom_range(0, 1));
    end
    comp = pending && (since >= 2) && !spi_busy && rst_n;
    sl = 0; sf = 0; e_wrap = 1'b0;
    if (comp && cur_addr >= SB && cur_addr < SB + SL) begin
      p = cur_addr - SB;
      marker(p, lh, fh);
      sf = fh;
      sl = lh && (!fh || FAL);
      e_wrap = (p == SL - 1);
    end
    e_ovr   = (sl && e_line) || (sf && e_frame);
    e_line  = sl ? 1'b1 : (line_done ? 1'b0 : e_line);
    e_frame = sf ? 1'b1 : (frame_done ? 1'b0 : e_frame);
    blocked = paused || holding;
    if (paused && !pause) paused = 0;
    if (holding && !go_home) holding = 0;
    if (comp) begin
      pending = 0;
      if (cur_addr == HA) begin exp_addr = SB; holding = 1; end
      else if (go_home) exp_addr = HA;
      else if (cur_addr < NI - 1) exp_addr = cur_addr + 1;
      else if (cur_addr == NI - 1) exp_addr = SB;
      else begin
        exp_addr = (cur_addr == SB + SL - 1) ? SB : cur_addr + 1;
        if (pause) paused = 1;
      end
    end
    @(posedge clk);
    #1;
    rom_data  = rom_mem[addr_prev[4:0]];
    addr_prev = rom_addr;
    #1;
    chk("new_line", 32'(new_line), 32'(e_line));
    chk("new_frame", 32'(new_frame), 32'(e_frame));
    chk("marker_overrun", 32'(marker_overrun), 32'(e_ovr));
    chk("scan_wrap", 32'(scan_wrap), 32'(e_wrap));
    start_now = spi_start;
    if (spi_start) begin
      chk("start_while_parked", 32'(blocked), 0);
      chk("start_while_busy", 32'(pending), 0);
      chk("start_addr", 32'(rom_addr), 32'(exp_addr));
      chk("data_mosi", 32'(data_mosi), 32'(rom_mem[exp_addr[4:0]]));
      cur_addr = exp_addr; pending = 1; since = 0; n_starts++;
    end else begin
      since++;
    end
    if (marker_overrun) ovr_seen++;
    if (new_line) line_seen++;
    if (bcnt > 0) begin spi_busy = 1'b1; bcnt--; end else spi_busy = 1'b0;
    if (spi_start) bcnt = 3;
  endtask

  task automatic wait_starts(input int n, input string tag);
    int target = n_starts + n;
    int budget = n * 20 + 40;
    while (n_starts < target && budget > 0) begin tick(); budget--; end
    chk(tag, 32'(n_starts >= target), 1);
  endtask

  task automatic wait_addr(input int a, input string tag);
    bit found = 0;
    int budget = 400;
    while (!found && budget > 0) begin
      tick(); budget--;
      found = start_now && (cur_addr == a);
    end
    chk(tag, 32'(found), 1);
  endtask

  initial begin
    int s0;
    for (int i = 0; i < 32; i++) rom_mem[i] = DW'($urandom);
    rst_n = 1'b0; start_init = 1'b0; pause = 1'b0; go_home = 1'b0;
    line_done = 1'b0; frame_done = 1'b0; rand_done = 0;
    n_starts = 0; ovr_seen = 0; line_seen = 0; start_now = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_spi_start", 32'(spi_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({new_line, new_frame, marker_overrun, scan_wrap}), 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", 32'(busy), 0);

    // Init order then a full loop with random flag acknowledgement.
    rand_done = 1;
    start_init = 1'b1; tick(); start_init = 1'b0;
    wait_starts(1, "init_start0"); chk("init_addr0", 32'(cur_addr), 0);
    wait_starts(1, "init_start1"); chk("init_addr1", 32'(cur_addr), 1);
    wait_starts(1, "scan_start0"); chk("scan_addr0", 32'(cur_addr), SB);
    chk("scan_busy", 32'(busy), 1);
    start_init = 1'b1; tick(); start_init = 1'b0;
    wait_starts(SL + 2, "full_loop");

    // Line flag left pending across two line markers.
    rand_done = 0; line_done = 1'b1; frame_done = 1'b1;
    wait_addr(SB, "ovr_sync");
    line_done = 1'b0; ovr_seen = 0;
    wait_starts(2 * SL, "ovr_loops");
    chk("ovr_count", 32'(ovr_seen), 1);
    chk("line_pending", 32'(new_line), 1);

    // Done asserted during the set cycle: flag shows for exactly one cycle.
    line_done = 1'b1; tick(); tick(); line_seen = 0;
    wait_starts(SL, "same_cycle_loop");
    chk("line_seen_once", 32'(line_seen), 1);

    // Pause during p=3.
    rand_done = 1;
    wait_addr(SB + 3, "pause_sync");
    pause = 1'b1; s0 = n_starts;
    repeat (12) tick();
    chk("pause_addr", 32'(rom_addr), SB + 4);
    chk("pause_busy", 32'(busy), 1);
    chk("pause_no_start", 32'(n_starts), 32'(s0));
    pause = 1'b0;
    wait_starts(1, "pause_resume"); chk("resume_addr", 32'(cur_addr), SB + 4);

    // Go home during p=6, park, release.
    wait_addr(SB + 6, "home_sync");
    go_home = 1'b1;
    wait_starts(1, "home_start"); chk("home_addr", 32'(cur_addr), HA);
    repeat (10) tick();
    chk("hold_busy", 32'(busy), 0);
    s0 = n_starts;
    repeat (6) tick();
    chk("hold_no_start", 32'(n_starts), 32'(s0));
    go_home = 1'b0;
    wait_starts(1, "home_release"); chk("release_addr", 32'(cur_addr), SB);
    wait_starts(SL + 1, "post_home_loop");

    // Asynchronous reset in the middle of a transfer.
    wait_starts(1, "rst_sync");
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rom_addr", 32'(rom_addr), 0);
    chk("arst_outputs", 32'({spi_start, new_line, new_frame, marker_overrun, scan_wrap, busy}), 0);
    rand_done = 0; line_done = 1'b0; frame_done = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    start_init = 1'b1; tick(); start_init = 1'b0;
    wait_starts(1, "reinit0"); chk("reinit_addr0", 32'(cur_addr), 0);
    wait_starts(1, "reinit1"); chk("reinit_addr1", 32'(cur_addr), 1);
    wait_starts(1, "reinit2"); chk("reinit_addr2", 32'(cur_addr), SB);
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
